// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants, FSM state encoding and the full-adder cell used by the
// sequential signed divider (seq_divider) and its subtractor (div_sub32).
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  // Wide enough to hold 0..DIV_ITERS-1 with headroom.
  localparam int CNT_WIDTH = 6;

  localparam logic [DIV_WIDTH-1:0] INT_MIN   = 32'h8000_0000;
  localparam logic [DIV_WIDTH-1:0] MINUS_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // One full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    full_add = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/div_sub32.sv
// -----------------------------------------------------------------------------
// div_sub32
// Combinational 32-bit subtractor built as a ripple of full-adder cells:
// diff = minuend + ~subtrahend + 1.
//
// Ports:
//   minuend    in  32  left operand
//   subtrahend in  32  right operand (inverted internally)
//   diff       out 32  minuend - subtrahend (mod 2^32)
//   carry_out  out 1   1 = no borrow (minuend >= subtrahend, unsigned)
//
// With minuend tied to zero this yields the two's-complement negation of
// subtrahend, which is how the divider does all of its sign handling.
// -----------------------------------------------------------------------------
module div_sub32
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] minuend,
  input  logic [DIV_WIDTH-1:0] subtrahend,
  output logic [DIV_WIDTH-1:0] diff,
  output logic                 carry_out
);

  logic [DIV_WIDTH-1:0] sub_inv;

  assign sub_inv = ~subtrahend;

  // The carry chain lives in a single process so the ripple is one
  // sequential walk rather than a self-referencing vector.
  always_comb begin
    logic       carry;
    logic [1:0] fa;
    carry = 1'b1;
    fa    = '0;
    diff  = '0;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      fa      = full_add(minuend[i], sub_inv[i], carry);
      diff[i] = fa[0];
      carry   = fa[1];
    end
    carry_out = carry;
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle signed 32-bit restoring divider. Quotient truncates toward zero,
// remainder takes the sign of the dividend. 32 iterations per operation;
// divide-by-zero and INT_MIN / -1 are resolved on the start edge.
//
// Ports:
//   clock           in  1      rising-edge clock
//   reset           in  1      synchronous, active-high
//   ctrl_DIV        in  1      start pulse; operands sampled on the same edge
//   data_operandA   in  WIDTH  dividend (two's complement)
//   data_operandB   in  WIDTH  divisor (two's complement)
//   data_result     out WIDTH  quotient (registered, held until next completion)
//   data_remainder  out WIDTH  remainder (registered, held)
//   data_exception  out 1      divide-by-zero or overflow (registered, held)
//   data_resultRDY  out 1      one-cycle completion strobe (decode of DONE)
//   dbg_state       out 2      current FSM state (div_state_t encoding)
//
// Handshake: data_resultRDY is a valid-only strobe with no back-pressure; the
// consumer samples result/remainder/exception in the cycle it is high. A start
// (ctrl_DIV) is accepted in any state: in RUN it abandons the operation in
// flight, which then never strobes data_resultRDY.
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_WIDTH-1:0] LAST_STEP = CNT_WIDTH'(DIV_ITERS - 1);

  div_state_t state, state_next;

  logic [CNT_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] rem;
  logic [DIV_WIDTH-1:0] quo;
  logic [DIV_WIDTH-1:0] divisor;
  logic                 qneg;
  logic                 rneg;

  // Operand magnitudes (unsigned, so |INT_MIN| = 0x80000000 is exact).
  logic [DIV_WIDTH-1:0] neg_a, neg_b, abs_a, abs_b;

  // One restoring step.
  logic [DIV_WIDTH-1:0] rem_shift, trial_diff, rem_step, quo_step;
  logic                 no_borrow;

  // Sign-corrected values of the step result, used on the final step.
  logic [DIV_WIDTH-1:0] neg_quo, neg_rem;

  logic [3:0] unused_carry;

  logic start_div0, start_ovf, start_exc, last_step;

  // ---------------------------------------------------------------------------
  // Start-edge decode
  // ---------------------------------------------------------------------------
  assign start_div0 = (data_operandB == '0);
  assign start_ovf  = (data_operandA == INT_MIN) && (data_operandB == MINUS_ONE);
  assign start_exc  = start_div0 || start_ovf;
  assign last_step  = (count == LAST_STEP);

  div_sub32 u_neg_a (
    .minuend    ('0),
    .subtrahend (data_operandA),
    .diff       (neg_a),
    .carry_out  (unused_carry[0])
  );

  div_sub32 u_neg_b (
    .minuend    ('0),
    .subtrahend (data_operandB),
    .diff       (neg_b),
    .carry_out  (unused_carry[1])
  );

  assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

  // ---------------------------------------------------------------------------
  // Restoring step. rem < divisor <= 2^31 always holds, so the shifted
  // remainder still fits in 32 bits and a 32-bit trial subtraction suffices.
  // ---------------------------------------------------------------------------
  assign rem_shift = {rem[DIV_WIDTH-2:0], quo[DIV_WIDTH-1]};

  div_sub32 u_trial (
    .minuend    (rem_shift),
    .subtrahend (divisor),
    .diff       (trial_diff),
    .carry_out  (no_borrow)
  );

  assign rem_step = no_borrow ? trial_diff : rem_shift;
  assign quo_step = {quo[DIV_WIDTH-2:0], no_borrow};

  // The final result registers load on the 32nd step edge, so sign
  // correction is applied to the step output directly.
  div_sub32 u_neg_quo (
    .minuend    ('0),
    .subtrahend (quo_step),
    .diff       (neg_quo),
    .carry_out  (unused_carry[2])
  );

  div_sub32 u_neg_rem (
    .minuend    ('0),
    .subtrahend (rem_step),
    .diff       (neg_rem),
    .carry_out  (unused_carry[3])
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (ctrl_DIV) begin
      // A start is honoured from every state, including mid-run.
      state_next = start_exc ? S_DONE : S_RUN;
    end else begin
      unique case (state)
        S_IDLE:  state_next = S_IDLE;
        S_RUN:   state_next = last_step ? S_DONE : S_RUN;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      rem            <= '0;
      quo            <= '0;
      divisor        <= '0;
      qneg           <= 1'b0;
      rneg           <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_DIV) begin
      count   <= '0;
      rem     <= '0;
      quo     <= abs_a;
      divisor <= abs_b;
      qneg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      rneg    <= data_operandA[WIDTH-1];
      // Exceptional operations complete right away; normal ones leave the
      // previous results in place until their own final step.
      if (start_exc) begin
        data_result    <= start_ovf ? INT_MIN : '0;
        data_remainder <= '0;
        data_exception <= 1'b1;
      end
    end else if (state == S_RUN) begin
      rem   <= rem_step;
      quo   <= quo_step;
      count <= count + 1'b1;
      if (last_step) begin
        data_result    <= qneg ? neg_quo : quo_step;
        data_remainder <= rneg ? neg_rem : rem_step;
        data_exception <= 1'b0;
      end
    end
  end

  assign data_resultRDY = (state == S_DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider. A reference model computes each operation's
// quotient/remainder/exception with plain signed arithmetic and the cycle on
// which completion must be visible; a compare process checks the ready strobe
// and the held result registers every cycle against it. Directed operations
// additionally check hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_seq_divider;
  import div_pkg::*;

  // Scoreboard entry: {done_cycle[96:65], exception[64], remainder[63:32], result[31:0]}
  localparam int W = 97;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];

  logic [31:0] cyc       = '0;
  logic        reset_q   = 1'b1;
  logic [31:0] start_cyc = '0;
  int          checks    = 0;
  int          errors    = 0;

  logic [31:0] held_res = '0;
  logic [31:0] held_rem = '0;
  logic        held_exc = 1'b0;

  seq_divider dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset bookkeeping
  // ---------------------------------------------------------------------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc     <= cyc + 32'd1;
    reset_q <= reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: {exception, remainder, result}
  function automatic logic [64:0] model_div(input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0)
      return {1'b1, 32'h0, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {1'b1, 32'h0, 32'h8000_0000};
    return {1'b0, 32'(sa % sb), 32'(sa / sb)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    logic [64:0] m;
    logic [31:0] done;
    @(posedge clock);
    #1;
    // An operation still in flight is abandoned by this start.
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1][96:65] > cyc)
      void'(exp_q.pop_back());
    m    = model_div(a, b);
    done = cyc + 32'd1 + (m[64] ? 32'd0 : 32'd32);
    exp_q.push_back({done, m});
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV  = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        lat = int'(cyc - start_cyc);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL rdy_timeout: got no ready within 40 cycles, expected a ready pulse");
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_res, input logic [31:0] e_rem,
                        input logic e_exc, input int e_lat);
    int lat;
    start_op(a, b);
    wait_rdy(lat);
    check({name, "_latency"}, 32'(lat), 32'(e_lat));
    check({name, "_result"}, data_result, e_res);
    check({name, "_remainder"}, data_remainder, e_rem);
    check({name, "_exception"}, {31'b0, data_exception}, {31'b0, e_exc});
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: model vs DUT every cycle
  // ---------------------------------------------------------------------------
  initial begin
    logic [W-1:0] e;
    logic         exp_rdy;
    forever begin
      @(negedge clock);
      exp_rdy = 1'b0;
      if (reset_q) begin
        exp_q.delete();
        held_res = '0;
        held_rem = '0;
        held_exc = 1'b0;
      end else if (exp_q.size() > 0 && exp_q[0][96:65] == cyc) begin
        e        = exp_q.pop_front();
        exp_rdy  = 1'b1;
        held_exc = e[64];
        held_rem = e[63:32];
        held_res = e[31:0];
      end
      check("sb_ready", {31'b0, data_resultRDY}, {31'b0, exp_rdy});
      check("sb_result", data_result, held_res);
      check("sb_remainder", data_remainder, held_rem);
      check("sb_exception", {31'b0, data_exception}, {31'b0, held_exc});
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [64:0] m;
    int          seen;
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    // Reset state, observed while reset is still held.
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_result", data_result, 32'h0);
    check("reset_remainder", data_remainder, 32'h0);
    check("reset_exception", {31'b0, data_exception}, 32'h0);
    check("reset_ready", {31'b0, data_resultRDY}, 32'h0);
    check("reset_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Pin the model against hand-computed values.
    m = model_div(32'd100, 32'd7);
    check("model_100_7", m[31:0], 32'd14);
    m = model_div(32'hFFFF_FF9C, 32'd7);
    check("model_m100_7_rem", m[63:32], 32'hFFFF_FFFE);
    m = model_div(32'h8000_0000, 32'hFFFF_FFFF);
    check("model_ovf", {m[64], m[31:0]} == {1'b1, 32'h8000_0000} ? 32'd1 : 32'd0, 32'd1);

    // Signed combinations.
    run_op("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32);
    run_op("neg_pos", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 32);
    run_op("pos_neg", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 32);
    run_op("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 32);
    run_op("max_by_min", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 32);

    // Divide by zero, then a normal operation clears the exception.
    run_op("div0", 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 0);
    run_op("after_div0", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 32);

    // Overflow and the legal INT_MIN case.
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 0);
    run_op("min_by_one", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 32);

    // Restart mid-run: only the second operation completes.
    start_op(32'd50, 32'd5);
    repeat (9) @(posedge clock);
    run_op("restart", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 32);

    // Reset in the middle of an operation.
    start_op(32'd1000, 32'd10);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midreset_result", data_result, 32'h0);
    check("midreset_remainder", data_remainder, 32'h0);
    check("midreset_ready", {31'b0, data_resultRDY}, 32'h0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) seen++;
    end
    check("midreset_no_ready", 32'(seen), 32'd0);
    run_op("after_reset", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32);

    // Back-to-back: second start lands in the first operation's DONE cycle.
    start_op(32'd9, 32'd3);
    repeat (31) @(posedge clock);
    run_op("back_to_back", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 32);

    repeat (3) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
